// File: rtl/ccsds123_pkg.sv
// Shared types and helpers for the CCSDS-123 bit unpacker.
// Optional protocol checks are enabled with CCSDS123_UNPACK_ERR_EN.
package ccsds123_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    function automatic int kw_of(input int d);
        return $clog2(d) + 1;
    endfunction

    // Codeword length from saturated zero run and k
    function automatic int cw_len(input int lz, input int k,
                                  input int umax, input int d);
        return (lz < umax) ? lz + 1 + k : umax + d;
    endfunction

    // Leading zeros of the top n bits of v, saturated at n
    function automatic int unsigned clz_sat(input logic [63:0] v,
                                            input int unsigned n);
        int unsigned r;
        r = n;
        for (int i = 63; i >= 0; i--) begin
            if (i < int'(n) && v[63-i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/ccsds123_clz.sv
// Saturating leading-zero counter over the UMAX-bit unary window.
module ccsds123_clz
    import ccsds123_pkg::*;
#(
    parameter int UMAX = 18,
    parameter int LZW  = $clog2(UMAX + 1)
) (
    input  logic [UMAX-1:0] i_bits,
    output logic [LZW-1:0]  o_lz
);

    logic [63:0] w_pad;

    always_comb begin
        w_pad = '0;
        w_pad[63 -: UMAX] = i_bits;
        o_lz = LZW'(clz_sat(w_pad, UMAX));
    end

endmodule

// File: rtl/ccsds123_bit_unpacker.sv
// Golomb-power-of-2 bitstream unpacker: one mapped residual per cycle.
// Define CCSDS123_UNPACK_ERR_EN for k-range and truncated-image checks.
module ccsds123_bit_unpacker
    import ccsds123_pkg::*;
#(
    parameter int BUS_WIDTH = 64,
    parameter int D         = 16,
    parameter int UMAX      = 18,
    parameter int NX        = 16,
    parameter int NY        = 16,
    parameter int NZ        = 8,
    parameter int KW        = kw_of(D)
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic [BUS_WIDTH-1:0] s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    input  logic [KW-1:0]        k_tdata,
    input  logic                 k_tvalid,
    output logic                 k_tready,
    output logic [D-1:0]         m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 err
);

    localparam int BW2      = 2 * BUS_WIDTH;
    localparam int FW       = $clog2(BW2 + 1);
    localparam int LZW      = $clog2(UMAX + 1);
    localparam int LW       = $clog2(UMAX + D + 1);
    localparam int NSAMPLES = NX * NY * NZ;
    localparam int CW       = (NSAMPLES > 1) ? $clog2(NSAMPLES) : 1;

    state_t             r_state, w_state_nx;
    logic [BW2-1:0]     r_buf, w_buf_nx, w_shifted, w_word_ext;
    logic [FW-1:0]      r_fill, w_fill_nx, w_fill_sh;
    logic [CW-1:0]      r_cnt;
    logic               r_rdy_en, r_last_seen, w_last_nx;
    logic [BUS_WIDTH-1:0] w_word;
    logic [LZW-1:0]     w_lz;
    logic [KW-1:0]      w_k;
    logic [LW-1:0]      w_len, w_sh;
    logic [D-1:0]       w_top, w_rem, w_res, w_out;
    logic               w_esc, w_have, w_free, w_dec, w_end;
    logic               w_acc, w_starve, w_more;

    ccsds123_clz #(.UMAX(UMAX), .LZW(LZW)) u_clz (
        .i_bits (r_buf[BW2-1 -: UMAX]),
        .o_lz   (w_lz)
    );

    // Reorder so the first transmitted bit is the word MSB
    always_comb begin
        w_word = '0;
        for (int i = 0; i < BUS_WIDTH / 8; i++)
            w_word[BUS_WIDTH-1-8*i -: 8] = s_axis_tdata[8*i +: 8];
    end

    always_comb begin
        w_k   = (k_tdata > KW'(D)) ? KW'(D) : k_tdata;
        w_esc = (w_lz == LZW'(UMAX));
        w_len = LW'(cw_len(int'(w_lz), int'(w_k), UMAX, D));
        w_sh  = w_esc ? LW'(UMAX) : LW'(w_lz) + LW'(1);
        w_top = D'(r_buf >> (FW'(BW2 - D) - FW'(w_sh)));
        w_rem = w_top >> (LW'(D) - LW'(w_k));
        w_res = w_esc ? w_top : ((D'(w_lz) << w_k) | w_rem);
        w_have = (r_fill >= FW'(w_len));
        w_free = !m_axis_tvalid || m_axis_tready;
    end

`ifdef CCSDS123_UNPACK_ERR_EN
    assign w_starve = r_last_seen && !w_have;
    assign w_more   = 1'b0;
`else
    assign w_starve = 1'b0;
    assign w_more   = k_tvalid && !w_have;
`endif

    assign w_dec = (r_state == ST_RUN) && k_tvalid && w_free
                && (w_have || w_starve);
    assign w_end = w_dec && (r_cnt == CW'(NSAMPLES - 1));
    assign w_out = w_have ? w_res : '0;
    assign k_tready = w_dec;

    // After tlast, hold off the next image unless this one is short
    assign s_axis_tready = r_rdy_en && ((r_state == ST_FLUSH)
        || ((r_fill <= FW'(BUS_WIDTH)) && (!r_last_seen || w_more)));
    assign w_acc = s_axis_tvalid && s_axis_tready;

    always_comb begin
        w_shifted  = w_dec ? (r_buf << w_len) : r_buf;
        w_fill_sh  = w_dec ? (r_fill - FW'(w_len)) : r_fill;
        w_word_ext = {w_word, {BUS_WIDTH{1'b0}}} >> w_fill_sh;
        w_buf_nx   = w_shifted;
        w_fill_nx  = w_fill_sh;
        w_last_nx  = r_last_seen;
        w_state_nx = r_state;
        unique case (r_state)
            ST_RUN: begin
                if (w_acc) begin
                    w_buf_nx  = w_shifted | w_word_ext;
                    w_fill_nx = w_fill_sh + FW'(BUS_WIDTH);
                    w_last_nx = s_axis_tlast;
                end
                if (w_dec && !w_have) begin
                    w_buf_nx  = '0;
                    w_fill_nx = '0;
                end
                if (w_end) begin
                    w_buf_nx   = '0;
                    w_fill_nx  = '0;
                    w_last_nx  = 1'b0;
                    w_state_nx = (r_last_seen || (w_acc && s_axis_tlast))
                               ? ST_RUN : ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_buf_nx  = '0;
                w_fill_nx = '0;
                if (w_acc && s_axis_tlast) w_state_nx = ST_RUN;
            end
            default: w_state_nx = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= ST_RUN;
            r_buf         <= '0;
            r_fill        <= '0;
            r_cnt         <= '0;
            r_rdy_en      <= 1'b0;
            r_last_seen   <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_buf       <= w_buf_nx;
            r_fill      <= w_fill_nx;
            r_last_seen <= w_last_nx;
            r_rdy_en    <= 1'b1;
            if (w_dec) begin
                r_cnt         <= w_end ? '0 : r_cnt + CW'(1);
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= w_out;
                m_axis_tlast  <= w_end;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

`ifdef CCSDS123_UNPACK_ERR_EN
    logic r_err;
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_err <= 1'b0;
        end else if (w_dec && ((k_tdata > KW'(D)) || !w_have)) begin
            r_err <= 1'b1;
        end
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ccsds123_bit_unpacker.sv
// Scoreboard bench for ccsds123_bit_unpacker (default configuration).
module tb_ccsds123_bit_unpacker;
    import ccsds123_pkg::*;

    localparam int BW   = 64;
    localparam int D    = 16;
    localparam int UMAX = 18;
    localparam int KW   = kw_of(D);
    localparam int NS   = 16 * 16 * 8;

    typedef struct packed {
        logic [D-1:0] d;
        logic         l;
    } exp_t;

    logic          clk = 1'b0;
    logic          aresetn;
    logic [BW-1:0] s_axis_tdata;
    logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [KW-1:0] k_tdata;
    logic          k_tvalid, k_tready;
    logic [D-1:0]  m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic          err;

    always #5 clk = ~clk;

    ccsds123_bit_unpacker #(
        .BUS_WIDTH(BW), .D(D), .UMAX(UMAX),
        .NX(16), .NY(16), .NZ(8), .KW(KW)
    ) dut (
        .clk(clk), .aresetn(aresetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .k_tdata(k_tdata), .k_tvalid(k_tvalid), .k_tready(k_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .err(err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    bit            bits_q[$];
    logic [BW-1:0] w_q[$];
    bit            l_q[$];
    logic [KW-1:0] k_q[$];
    exp_t          exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic put_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) bits_q.push_back(v[i]);
    endtask

    // Reference Golomb encoder with escape after UMAX zeros
    task automatic enc(input logic [D-1:0] r, input int k);
        int u;
        u = int'(r) >> k;
        if (u < UMAX) begin
            put_bits(64'd0, u);
            put_bits(64'd1, 1);
            put_bits({48'd0, r}, k);
        end else begin
            put_bits(64'd0, UMAX);
            put_bits({48'd0, r}, D);
        end
        k_q.push_back(KW'(k));
    endtask

    task automatic build_image(input bit directed, input int extra);
        logic [D-1:0]  r;
        logic [BW-1:0] w;
        int            k, t, nb;
        for (int n = 0; n < NS; n++) begin
            k = $urandom_range(0, D);
            t = ($urandom_range(0, 21) << k)
              | int'($urandom & ((32'd1 << k) - 1));
            r = t[D-1:0];
            if (directed && n == 0) begin r = 16'd5;    k = 2; end
            if (directed && n == 1) begin r = 16'd0;    k = 0; end
            if (directed && n == 2) begin r = 16'hABCD; k = 0; end
            if (directed && n == 3) begin r = 16'hABCD; k = 5; end
            enc(r, k);
            exp_q.push_back('{d: r, l: (n == NS - 1)});
        end
        nb = (BW - bits_q.size() % BW) % BW + extra * BW;
        repeat (nb) bits_q.push_back(1'($urandom_range(0, 1)));
        while (bits_q.size() > 0) begin
            w = '0;
            for (int j = 0; j < BW; j++)
                w[8*(j/8) + 7 - (j%8)] = bits_q.pop_front();
            w_q.push_back(w);
            l_q.push_back(bits_q.size() == 0);
        end
    endtask

    task automatic run(input int max_out, input int stall_at);
        int       outs = 0;
        int       cyc = 0;
        int       stall = 0;
        bit       held = 0;
        logic [D:0] hv = '0;
        exp_t     e;
        while ((exp_q.size() > 0 || w_q.size() > 0) && outs < max_out) begin
            @(negedge clk);
            cyc++;
            if (cyc > 40000) begin
                chk("timeout_cycles", cyc, 40000);
                break;
            end
            if (stall_at >= 0 && outs == stall_at) begin
                stall = 30;
                stall_at = -1;
            end
            s_axis_tvalid = (w_q.size() > 0) && ($urandom_range(0, 3) != 0);
            s_axis_tdata  = (w_q.size() > 0) ? w_q[0] : '0;
            s_axis_tlast  = (l_q.size() > 0) ? l_q[0] : 1'b0;
            k_tvalid = (k_q.size() > 0) && ($urandom_range(0, 7) != 0);
            k_tdata  = (k_q.size() > 0) ? k_q[0] : '0;
            if (stall > 0) begin
                m_axis_tready = 1'b0;
                stall--;
            end else begin
                m_axis_tready = ($urandom_range(0, 7) != 0);
            end
            #1;
            if (held && m_axis_tvalid)
                chk("hold", {m_axis_tlast, m_axis_tdata}, hv);
            held = m_axis_tvalid && !m_axis_tready;
            hv   = {m_axis_tlast, m_axis_tdata};
            if (s_axis_tvalid && s_axis_tready) begin
                w_q.delete(0);
                l_q.delete(0);
            end
            if (k_tvalid && k_tready) k_q.delete(0);
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_out", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("residual", m_axis_tdata, e.d);
                    chk("tlast", m_axis_tlast, e.l);
                    outs++;
                end
            end
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        k_tvalid      = 1'b0;
        m_axis_tready = 1'b1;
    endtask

    task automatic idle_check(input string tag);
        int ex = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (m_axis_tvalid) ex++;
        end
        chk(tag, ex, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mvalid"}, m_axis_tvalid, 0);
        chk({tag, "_mlast"}, m_axis_tlast, 0);
        chk({tag, "_mdata"}, m_axis_tdata, 0);
        chk({tag, "_sready"}, s_axis_tready, 0);
        chk({tag, "_kready"}, k_tready, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic release_reset(input string tag);
        @(negedge clk);
        aresetn = 1'b1;
        #1 chk({tag, "_rdy_release"}, s_axis_tready, 0);
        @(negedge clk);
        #1 chk({tag, "_rdy_after"}, s_axis_tready, 1);
    endtask

    initial begin
        aresetn       = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        k_tdata       = '0;
        k_tvalid      = 1'b0;
        m_axis_tready = 1'b1;
        #2 aresetn = 1'b0;
        #1 check_reset_outputs("por");
        repeat (3) @(posedge clk);
        release_reset("por");

        build_image(1'b1, 0);
        build_image(1'b0, 3);
        run(1 << 30, 500);
        chk("img12_exp_left", exp_q.size(), 0);
        chk("img12_words_left", w_q.size(), 0);
        chk("img12_k_left", k_q.size(), 0);
        idle_check("img12_no_extra");

        build_image(1'b0, 0);
        run(300, -1);
        #2 aresetn = 1'b0;
        #1 check_reset_outputs("mid");
        w_q.delete();
        l_q.delete();
        k_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        release_reset("mid");

        build_image(1'b1, 1);
        run(1 << 30, -1);
        chk("img3_exp_left", exp_q.size(), 0);
        chk("img3_words_left", w_q.size(), 0);
        idle_check("img3_no_extra");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
